// File: rtl/booth_pp_accum.sv
// booth_pp_accum
// Iterative accumulator for radix-4 Booth partial products. Each accepted
// partial product i (with its two's-complement correction carry) is weighted
// by 4^i (shift by 2*i) and added into a WIDTH-bit accumulator, modulo
// 2^WIDTH. After PP_NUM products the sum is offered on a valid/ready port.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   resetn     : synchronous active-low reset (highest priority)
//   flush      : synchronous abort of the current multiplication
//   in_valid   : partial product present
//   in_ready   : block accepts a partial product (registered, ACCUM state)
//   in_pp      : Booth partial product, bit-inverted when negative
//   in_carry   : +1 correction for negative partial products
//   out_valid  : result valid (registered, DONE state)
//   out_ready  : consumer accepts the result
//   out_result : accumulated product, modulo 2^WIDTH
module booth_pp_accum #(
    parameter int WIDTH  = 64,
    parameter int PP_NUM = 17
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pp,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int IDX_W = (PP_NUM > 1) ? $clog2(PP_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PP_NUM - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_beat;
    logic             w_out_hs;
    logic [IDX_W:0]   w_shamt;
    logic [WIDTH-1:0] w_pp_sh;
    logic [WIDTH-1:0] w_carry_sh;
    logic [WIDTH-1:0] w_acc_next;

    // Handshake decode and weighted partial-product sum for the current index
    always_comb begin
        w_beat     = 1'b0;
        w_out_hs   = 1'b0;
        w_shamt    = {r_idx, 1'b0};
        w_pp_sh    = {WIDTH{1'b0}};
        w_carry_sh = {WIDTH{1'b0}};
        w_acc_next = r_acc;
        w_beat     = in_valid & r_in_ready;
        w_out_hs   = r_out_valid & out_ready;
        // Shifting both terms separately keeps the carry at the same weight
        // as its partial product; bits above WIDTH-1 simply fall off.
        w_pp_sh    = in_pp << w_shamt;
        w_carry_sh = {{(WIDTH-1){1'b0}}, in_carry} << w_shamt;
        w_acc_next = r_acc + w_pp_sh + w_carry_sh;
    end

    // Control FSM, accumulator and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_ACCUM;
            r_acc       <= {WIDTH{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            // Flush wins over any beat or output handshake in this cycle
            r_state     <= ST_ACCUM;
            r_acc       <= {WIDTH{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        if (r_idx == IDX_LAST) begin
                            r_idx       <= {IDX_W{1'b0}};
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                ST_DONE: begin
                    if (w_out_hs) begin
                        r_acc       <= {WIDTH{1'b0}};
                        r_state     <= ST_ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_acc       <= {WIDTH{1'b0}};
                    r_idx       <= {IDX_W{1'b0}};
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_acc;

endmodule
